mfcc_dct_stream: RTL

- Parametrised streaming DCT-II stage of the MFCC front end, between the log-mel block and the feature buffer.
- Accepts frames of `N_IN` log-energies over a valid/ready stream and returns `N_OUT` cepstral coefficients, one per output handshake.
- Ping-pong input banks let the next frame be accepted while the current one is transformed.
- A runtime mode drops c0 so the energy term can be substituted downstream.

---
 rtl/mfcc_pkg.sv | 40 ++++
 rtl/dct_coeff_rom.sv | 29 ++
 rtl/mfcc_dct_stream.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mfcc_pkg.sv
// Shared defaults, derived widths and engine state encoding for the MFCC DCT stage.
// The coefficient helper builds the same table as the offline hex generator.
package mfcc_pkg;

  localparam int    DEF_N_IN      = 32;
  localparam int    DEF_N_OUT     = 13;
  localparam int    DEF_DATA_W    = 16;
  localparam int    DEF_Q_IN      = 11;
  localparam int    DEF_COEF_W    = 16;
  localparam int    DEF_Q_COEF    = 15;
  localparam int    DEF_Q_OUT     = 4;
  localparam string DEF_COEF_FILE = "dct_coef.hex";

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_FLUSH,
    ST_OUT
  } engine_state_e;

  function automatic int acc_width(input int data_w, input int coef_w, input int n_in);
    return data_w + coef_w + $clog2(n_in);
  endfunction

  function automatic int out_shift(input int q_in, input int q_coef, input int q_out);
    return q_in + q_coef - q_out;
  endfunction

  // Orthonormal DCT-II basis entry, rounded half away from zero to q_coef fractional bits.
  function automatic int dct_coef_q(input int k, input int n, input int n_in, input int q_coef);
    real pi_v;
    real scale;
    real v;
    pi_v  = 3.14159265358979323846;
    scale = (k == 0) ? $sqrt(1.0 / n_in) : $sqrt(2.0 / n_in);
    v     = scale * $cos(pi_v * (2 * n + 1) * k / (2.0 * n_in)) * (2.0 ** q_coef);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/dct_coeff_rom.sv
// N_OUT x N_IN DCT-II coefficient ROM, addressed k*N_IN+n, combinational read.
// Entries are computed at elaboration from the package coefficient helper.
module dct_coeff_rom
  import mfcc_pkg::*;
#(
  parameter int    N_IN      = DEF_N_IN,
  parameter int    N_OUT     = DEF_N_OUT,
  parameter int    COEF_W    = DEF_COEF_W,
  parameter int    Q_COEF    = DEF_Q_COEF,
  parameter string COEF_FILE = DEF_COEF_FILE,
  parameter int    AW        = $clog2(N_OUT * N_IN)
) (
  input  logic [AW-1:0]            addr,
  output logic signed [COEF_W-1:0] coef
);

  localparam int DEPTH = N_OUT * N_IN;

  logic signed [COEF_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < N_OUT; k++) begin : g_k
    for (genvar n = 0; n < N_IN; n++) begin : g_n
      assign rom[k * N_IN + n] = COEF_W'(dct_coef_q(k, n, N_IN, Q_COEF));
    end
  end

  assign coef = rom[addr];

endmodule

// File: rtl/mfcc_dct_stream.sv
// Streaming DCT-II stage: frames of N_IN log-mel samples in, N_OUT cepstra out.
// Ping-pong input banks let the next frame load while one serial MAC engine works.
//
// state    | meaning
// ST_IDLE  | wait for a full read bank; latch skip-c0, choose starting k
// ST_MAC   | one product per cycle over n = 0..N_IN-1
// ST_FLUSH | final add, round, shift, saturate into out_*
// ST_OUT   | hold out_* until out_ready; release bank after last k
module mfcc_dct_stream
  import mfcc_pkg::*;
#(
  parameter int    N_IN      = DEF_N_IN,
  parameter int    N_OUT     = DEF_N_OUT,
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    Q_IN      = DEF_Q_IN,
  parameter int    COEF_W    = DEF_COEF_W,
  parameter int    Q_COEF    = DEF_Q_COEF,
  parameter int    Q_OUT     = DEF_Q_OUT,
  parameter string COEF_FILE = DEF_COEF_FILE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_W-1:0]     in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         cfg_skip_c0,
  output logic signed [DATA_W-1:0]     out_data,
  output logic [$clog2(N_OUT+1)-1:0]   out_idx,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int NW    = $clog2(N_IN);
  localparam int KW    = $clog2(N_OUT + 1);
  localparam int AW    = $clog2(N_OUT * N_IN);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, N_IN);
  localparam int SH    = out_shift(Q_IN, Q_COEF, Q_OUT);
  localparam int RW    = ACC_W + 1;

  localparam logic [NW-1:0] N_LAST = NW'(N_IN - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);

  localparam logic signed [RW-1:0] BIAS    = RW'(1) << (SH - 1);
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] bank_mem [2][N_IN];
  logic [1:0]               full;
  logic [1:0]               full_nxt;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [NW-1:0]            wr_idx;
  logic                     in_fire;
  logic                     wr_wrap;

  engine_state_e            state;
  engine_state_e            state_nxt;
  logic                     start_frame;
  logic                     next_coef;
  logic                     bank_release;
  logic [NW-1:0]            n_cnt;
  logic [KW-1:0]            k_cnt;
  logic [AW-1:0]            rom_addr;
  logic signed [COEF_W-1:0] coef;
  logic signed [DATA_W-1:0] sample;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     preg;
  logic signed [ACC_W-1:0]  acc;
  logic signed [RW-1:0]     sum_w;
  logic signed [RW-1:0]     rnd_w;
  logic signed [RW-1:0]     shf_w;
  logic signed [DATA_W-1:0] sat_w;

  assign in_ready = !full[wr_bank];
  assign in_fire  = in_valid && in_ready;
  assign wr_wrap  = in_fire && (wr_idx == N_LAST);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (in_fire) begin
      bank_mem[wr_bank][wr_idx] <= in_data;
    end
  end

  // Release and fill always target different banks, so both edits apply.
  always_comb begin
    full_nxt = full;
    if (bank_release) full_nxt[rd_bank] = 1'b0;
    if (wr_wrap)      full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      rd_bank <= 1'b0;
      full    <= '0;
    end else begin
      full <= full_nxt;
      if (in_fire) begin
        wr_idx <= wr_wrap ? '0 : wr_idx + 1'b1;
        if (wr_wrap) wr_bank <= ~wr_bank;
      end
      if (bank_release) rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_frame  = 1'b0;
    next_coef    = 1'b0;
    bank_release = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (full[rd_bank]) begin
          // A one-coefficient frame with c0 dropped has nothing to compute.
          if (cfg_skip_c0 && (N_OUT == 1)) begin
            bank_release = 1'b1;
          end else begin
            start_frame = 1'b1;
            state_nxt   = ST_MAC;
          end
        end
      end
      ST_MAC: begin
        if (n_cnt == N_LAST) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (out_last) begin
            bank_release = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            next_coef = 1'b1;
            state_nxt = ST_MAC;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rom_addr = AW'(int'(k_cnt) * N_IN + int'(n_cnt));
  assign sample   = bank_mem[rd_bank][n_cnt];
  assign prod     = sample * coef;

  dct_coeff_rom #(
    .N_IN      (N_IN),
    .N_OUT     (N_OUT),
    .COEF_W    (COEF_W),
    .Q_COEF    (Q_COEF),
    .COEF_FILE (COEF_FILE),
    .AW        (AW)
  ) u_rom (
    .addr (rom_addr),
    .coef (coef)
  );

  always_comb begin
    sum_w = RW'(acc) + RW'(preg);
    rnd_w = sum_w + BIAS;
    shf_w = rnd_w >>> SH;
    if (shf_w > SAT_MAX)      sat_w = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shf_w < SAT_MIN) sat_w = {1'b1, {(DATA_W-1){1'b0}}};
    else                      sat_w = shf_w[DATA_W-1:0];
  end

  // preg is cleared with acc so the first MAC cycle adds nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cnt     <= '0;
      k_cnt     <= '0;
      preg      <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (start_frame)    k_cnt <= cfg_skip_c0 ? KW'(1) : '0;
      else if (next_coef) k_cnt <= k_cnt + 1'b1;

      if (start_frame || next_coef) begin
        n_cnt <= '0;
        preg  <= '0;
        acc   <= '0;
      end else if (state == ST_MAC) begin
        preg  <= prod;
        acc   <= acc + ACC_W'(preg);
        n_cnt <= (n_cnt == N_LAST) ? '0 : n_cnt + 1'b1;
      end

      if (state == ST_FLUSH) begin
        out_data  <= sat_w;
        out_idx   <= k_cnt;
        out_last  <= (k_cnt == K_LAST);
        out_valid <= 1'b1;
      end else if ((state == ST_OUT) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
